// File: rtl/pwm_cfg_pkg.sv
// rtl/pwm_cfg_pkg.sv - shared constants, FSM state encoding and bank geometry for the PWM config scheduler
package pwm_cfg_pkg;

    localparam int BANK_BYTES = 5;
    localparam int BANK_W     = BANK_BYTES * 8;

    localparam logic [6:0] ADDR_EN_OUT_LO = 7'h00;
    localparam logic [6:0] ADDR_EN_OUT_HI = 7'h01;
    localparam logic [6:0] ADDR_EN_PWM_LO = 7'h02;
    localparam logic [6:0] ADDR_EN_PWM_HI = 7'h03;
    localparam logic [6:0] ADDR_DUTY      = 7'h04;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_ARMED  = 2'd1;
    localparam state_t ST_COMMIT = 2'd2;

    function automatic logic addr_mapped(input logic [6:0] addr);
        return addr <= ADDR_DUTY;
    endfunction

endpackage

// File: rtl/pwm_cfg_regbank.sv
// rtl/pwm_cfg_regbank.sv - five-byte configuration bank with byte writes and an atomic full-bank load
module pwm_cfg_regbank
    import pwm_cfg_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_wr_en,
    input  logic [2:0]        i_wr_idx,
    input  logic [7:0]        i_wr_data,
    input  logic              i_load,
    input  logic [BANK_W-1:0] i_load_data,
    output logic [BANK_W-1:0] o_bank
);

    logic [BANK_W-1:0] r_bank;

    // A full load wins over a byte write so a commit is never torn.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bank <= '0;
        end else if (i_load) begin
            r_bank <= i_load_data;
        end else if (i_wr_en) begin
            for (int i = 0; i < BANK_BYTES; i++) begin
                if (i_wr_idx == 3'(i)) begin
                    r_bank[i*8 +: 8] <= i_wr_data;
                end
            end
        end
    end

    assign o_bank = r_bank;

endmodule

// File: rtl/pwm_cfg_scheduler.sv
// rtl/pwm_cfg_scheduler.sv - shadow/active PWM config banks committed on a period boundary or timeout
// Optional feature: PWM_CFG_AUTOCOMMIT_EN makes every mapped write arm a commit on its own.
module pwm_cfg_scheduler
    import pwm_cfg_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wr_valid,
    output logic        wr_ready,
    input  logic [6:0]  wr_addr,
    input  logic [7:0]  wr_data,
    input  logic        commit_req,
    input  logic        period_end,
    output logic [15:0] en_out,
    output logic [15:0] en_pwm_mode,
    output logic [7:0]  pwm_duty_cycle,
    output logic        pending,
    output logic        err_addr,
    output logic        timeout
);

    localparam int              CNT_W      = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic            TIMEOUT_EN = (TIMEOUT_CYCLES > 0);

    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_pending;
    logic              r_err;
    logic              r_timeout;

    logic              w_wr_acc;
    logic              w_mapped;
    logic              w_shadow_we;
    logic              w_arm_req;
    logic              w_to_hit;
    logic              w_commit;
    logic [BANK_W-1:0] w_shadow;
    logic [BANK_W-1:0] w_active;

    assign wr_ready    = (r_state == ST_IDLE);
    assign w_wr_acc    = wr_valid && wr_ready;
    assign w_mapped    = addr_mapped(wr_addr);
    assign w_shadow_we = w_wr_acc && w_mapped;
    assign w_to_hit    = TIMEOUT_EN && (r_cnt == CNT_LAST);
    assign w_commit    = (r_state == ST_COMMIT);

`ifdef PWM_CFG_AUTOCOMMIT_EN
    assign w_arm_req = commit_req || w_shadow_we;
`else
    assign w_arm_req = commit_req;
`endif

    // Writes are only accepted in IDLE and pending only clears in COMMIT, so set/clear never collide.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_pending <= 1'b0;
            r_err     <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_err     <= w_wr_acc && !w_mapped;
            r_timeout <= 1'b0;
            if (w_shadow_we) begin
                r_pending <= 1'b1;
            end
            case (r_state)
                ST_IDLE: begin
                    if (w_arm_req && (r_pending || w_shadow_we)) begin
                        r_state <= ST_ARMED;
                        r_cnt   <= '0;
                    end
                end
                ST_ARMED: begin
                    if (period_end) begin
                        r_state <= ST_COMMIT;
                    end else if (w_to_hit) begin
                        r_state   <= ST_COMMIT;
                        r_timeout <= 1'b1;
                    end else if (r_cnt != '1) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_COMMIT: begin
                    r_state   <= ST_IDLE;
                    r_pending <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    pwm_cfg_regbank u_shadow (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_wr_en     (w_shadow_we),
        .i_wr_idx    (wr_addr[2:0]),
        .i_wr_data   (wr_data),
        .i_load      (1'b0),
        .i_load_data ('0),
        .o_bank      (w_shadow)
    );

    pwm_cfg_regbank u_active (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_wr_en     (1'b0),
        .i_wr_idx    (3'd0),
        .i_wr_data   (8'd0),
        .i_load      (w_commit),
        .i_load_data (w_shadow),
        .o_bank      (w_active)
    );

    assign en_out         = {w_active[ADDR_EN_OUT_HI*8 +: 8], w_active[ADDR_EN_OUT_LO*8 +: 8]};
    assign en_pwm_mode    = {w_active[ADDR_EN_PWM_HI*8 +: 8], w_active[ADDR_EN_PWM_LO*8 +: 8]};
    assign pwm_duty_cycle = w_active[ADDR_DUTY*8 +: 8];
    assign pending        = r_pending;
    assign err_addr       = r_err;
    assign timeout        = r_timeout;

endmodule

// File: tb/tb_pwm_cfg_scheduler.sv
// tb/tb_pwm_cfg_scheduler.sv - scoreboard bench for pwm_cfg_scheduler (default and 8-cycle timeout instances)
module tb_pwm_cfg_scheduler;

    typedef struct packed {
        logic [15:0] en;
        logic [15:0] pm;
        logic [7:0]  duty;
        logic        err;
        logic        to;
    } obs_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        wr_valid = 1'b0;
    logic [6:0]  wr_addr = '0;
    logic [7:0]  wr_data = '0;
    logic        commit_req = 1'b0;
    logic        period_end = 1'b0;

    logic        wr_ready_a, pending_a, err_a, to_a;
    logic [15:0] en_a, pm_a;
    logic [7:0]  duty_a;
    logic        wr_ready_b, pending_b, err_b, to_b;
    logic [15:0] en_b, pm_b;
    logic [7:0]  duty_b;

    int   n_tests = 0;
    int   n_fail  = 0;
    obs_t qa[$];
    obs_t qb[$];
    obs_t prev_a = '0;
    obs_t prev_b = '0;

    always #5 clk = ~clk;

    pwm_cfg_scheduler u_dut (
        .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_ready(wr_ready_a),
        .wr_addr(wr_addr), .wr_data(wr_data), .commit_req(commit_req), .period_end(period_end),
        .en_out(en_a), .en_pwm_mode(pm_a), .pwm_duty_cycle(duty_a),
        .pending(pending_a), .err_addr(err_a), .timeout(to_a)
    );

    pwm_cfg_scheduler #(.TIMEOUT_CYCLES(8)) u_dut_t8 (
        .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_ready(wr_ready_b),
        .wr_addr(wr_addr), .wr_data(wr_data), .commit_req(commit_req), .period_end(period_end),
        .en_out(en_b), .en_pwm_mode(pm_b), .pwm_duty_cycle(duty_b),
        .pending(pending_b), .err_addr(err_b), .timeout(to_b)
    );

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    function automatic obs_t ob(input logic [15:0] en, input logic [15:0] pm, input logic [7:0] du,
                                input logic er, input logic tm);
        return {en, pm, du, er, tm};
    endfunction

    task automatic exp_both(input obs_t o);
        qa.push_back(o);
        qb.push_back(o);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [6:0] a, input logic [7:0] d);
        wr_valid = 1'b1;
        wr_addr  = a;
        wr_data  = d;
        step();
        wr_valid = 1'b0;
    endtask

    task automatic commit();
        commit_req = 1'b1;
        step();
        commit_req = 1'b0;
    endtask

    task automatic pulse_period_end();
        period_end = 1'b1;
        step();
        period_end = 1'b0;
    endtask

    // Monitors: any change of the active outputs or any err/timeout pulse is one observed response.
    always @(negedge clk) begin : mon_a
        obs_t cur;
        obs_t e;
        cur = {en_a, pm_a, duty_a, err_a, to_a};
        if (cur.en != prev_a.en || cur.pm != prev_a.pm || cur.duty != prev_a.duty || cur.err || cur.to) begin
            if (qa.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL mon_a_unexpected: got %h expected no response", cur);
            end else begin
                e = qa.pop_front();
                chk("mon_a", cur, e);
            end
        end
        prev_a = cur;
    end

    always @(negedge clk) begin : mon_b
        obs_t cur;
        obs_t e;
        cur = {en_b, pm_b, duty_b, err_b, to_b};
        if (cur.en != prev_b.en || cur.pm != prev_b.pm || cur.duty != prev_b.duty || cur.err || cur.to) begin
            if (qb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL mon_b_unexpected: got %h expected no response", cur);
            end else begin
                e = qb.pop_front();
                chk("mon_b", cur, e);
            end
        end
        prev_b = cur;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        #1 rst_n = 1'b0;
        #2;
        chk("rst_en_out", en_a, 16'h0);
        chk("rst_pwm_mode", pm_a, 16'h0);
        chk("rst_duty", duty_a, 8'h0);
        chk("rst_pending", pending_a, 1'b0);
        chk("rst_err", err_a, 1'b0);
        chk("rst_timeout", to_b, 1'b0);
        step();
        step();
        rst_n = 1'b1;
        step();
        chk("idle_wr_ready", wr_ready_a, 1'b1);

`ifdef PWM_CFG_AUTOCOMMIT_EN
        exp_both(ob(16'h0000, 16'h000F, 8'h00, 1'b0, 1'b0));
        wr(7'h02, 8'h0F);
        chk("auto_armed_wr_ready", wr_ready_a, 1'b0);
        chk("auto_pending", pending_a, 1'b1);
        pulse_period_end();
        chk("auto_before_commit", pm_a, 16'h0000);
        step();
        chk("auto_pwm_mode", pm_a, 16'h000F);
        chk("auto_pending_clr", pending_a, 1'b0);
`else
        // Batched commit; the 8-cycle instance times out before period_end arrives.
        qa.push_back(ob(16'h00A5, 16'h0000, 8'h80, 1'b0, 1'b0));
        qb.push_back(ob(16'h0000, 16'h0000, 8'h00, 1'b0, 1'b1));
        qb.push_back(ob(16'h00A5, 16'h0000, 8'h80, 1'b0, 1'b0));
        wr(7'h00, 8'hA5);
        wr(7'h04, 8'h80);
        chk("s1_pending_set", pending_a, 1'b1);
        commit();
        chk("s1_armed_wr_ready", wr_ready_a, 1'b0);
        for (int i = 1; i <= 9; i++) begin
            step();
            if (i == 7) chk("t8_no_early_timeout", to_b, 1'b0);
            if (i == 8) chk("t8_timeout_pulse", to_b, 1'b1);
            if (i == 8) chk("t8_active_before_load", en_b, 16'h0000);
            if (i == 9) chk("t8_active_eq_shadow", {en_b, duty_b}, {16'h00A5, 8'h80});
            if (i == 9) chk("t8_pending_clr", pending_b, 1'b0);
        end
        pulse_period_end();
        chk("s1_one_edge_after_pe", en_a, 16'h0000);
        chk("s1_pending_still", pending_a, 1'b1);
        step();
        chk("s1_en_out", en_a, 16'h00A5);
        chk("s1_duty", duty_a, 8'h80);
        chk("s1_pending_clr", pending_a, 1'b0);

        // Writes offered while armed must be refused.
        exp_both(ob(16'h003C, 16'h0000, 8'h80, 1'b0, 1'b0));
        wr(7'h00, 8'h3C);
        commit();
        wr_valid = 1'b1;
        wr_addr  = 7'h01;
        wr_data  = 8'hFF;
        for (int i = 0; i < 3; i++) begin
            chk("s2_armed_wr_ready", wr_ready_a, 1'b0);
            step();
        end
        wr_valid = 1'b0;
        pulse_period_end();
        step();
        chk("s2_en_out_hi_kept", en_a[15:8], 8'h00);
        chk("s2_en_out", en_a, 16'h003C);

        // Unmapped addresses, including both ends of the unmapped range.
        exp_both(ob(16'h003C, 16'h0000, 8'h80, 1'b1, 1'b0));
        wr(7'h10, 8'h55);
        exp_both(ob(16'h003C, 16'h0000, 8'h80, 1'b1, 1'b0));
        wr(7'h05, 8'h77);
        exp_both(ob(16'h003C, 16'h0000, 8'h80, 1'b1, 1'b0));
        wr(7'h7F, 8'h01);
        step();
        chk("s3_pending_unchanged", pending_a, 1'b0);
        chk("s3_wr_ready", wr_ready_a, 1'b1);

        // Write + commit_req in one cycle; period_end on the arming edge is not counted.
        exp_both(ob(16'h003C, 16'h1200, 8'h80, 1'b0, 1'b0));
        wr_valid   = 1'b1;
        wr_addr    = 7'h03;
        wr_data    = 8'h12;
        commit_req = 1'b1;
        period_end = 1'b1;
        step();
        wr_valid   = 1'b0;
        commit_req = 1'b0;
        period_end = 1'b0;
        chk("s4_armed", wr_ready_a, 1'b0);
        chk("s4_pending", pending_a, 1'b1);
        step();
        chk("s4_pe_at_arm_ignored", pm_a, 16'h0000);
        step();
        chk("s4_still_armed", pm_a, 16'h0000);
        pulse_period_end();
        step();
        chk("s4_pwm_mode", pm_a, 16'h1200);

        // commit_req with nothing pending stays in IDLE.
        commit();
        chk("s5_commit_ignored", wr_ready_a, 1'b1);
        pulse_period_end();
        step();
        chk("s5_no_change", pm_a, 16'h1200);

        // Reset while armed discards the shadow bank.
        wr(7'h04, 8'h40);
        commit();
        step();
        exp_both(ob(16'h0000, 16'h0000, 8'h00, 1'b0, 1'b0));
        rst_n = 1'b0;
        #2;
        chk("s6_rst_en_out", en_a, 16'h0000);
        chk("s6_rst_pwm_mode", pm_a, 16'h0000);
        chk("s6_rst_duty", duty_a, 8'h00);
        step();
        step();
        rst_n = 1'b1;
        step();
        chk("s6_pending_after", pending_a, 1'b0);
        chk("s6_wr_ready_after", wr_ready_a, 1'b1);
        exp_both(ob(16'h0001, 16'h0000, 8'h00, 1'b0, 1'b0));
        wr(7'h00, 8'h01);
        commit();
        pulse_period_end();
        step();
        chk("s6_shadow_discarded", {en_a, duty_a}, {16'h0001, 8'h00});
`endif

        repeat (4) step();
        chk("qa_drained", qa.size(), 0);
        chk("qb_drained", qb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
